// File: rtl/sub16_seq_ctrl.sv
// rtl/sub16_seq_ctrl.sv - sequential 16-bit subtractor controller driving an external 4-bit slice
//
// Purpose: runs a 16-bit subtract as four nibble passes through an external
// 4-bit full-subtractor slice. The borrow is chained through a register.
// Supported ops are SUB (a-b), SBC (a-b-bin), CMP (flags only) and RSB (b-a).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               request an operation (accepted in IDLE only)
//   op[1:0]             00 SUB, 01 SBC, 10 CMP, 11 RSB
//   a, b [15:0]         operands, captured when start is accepted
//   bin                 borrow-in, SBC only
//   busy                high while the nibble passes run
//   done                one-cycle completion pulse
//   result[15:0]        difference register (left untouched by CMP)
//   flag_z/n/b/v        zero, negative, borrow-out, signed overflow
//   slice_a/b[3:0]      nibble operands to the slice (zero outside RUN)
//   slice_bin           borrow into the slice (zero outside RUN)
//   slice_diff[3:0]     nibble difference from the slice
//   slice_bout          borrow out of the slice

module sub16_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        flag_z,
   output logic        flag_n,
   output logic        flag_b,
   output logic        flag_v,
   output logic [3:0]  slice_a,
   output logic [3:0]  slice_b,
   output logic        slice_bin,
   input  logic [3:0]  slice_diff,
   input  logic        slice_bout
);

   localparam logic [1:0] OP_SUB = 2'b00;
   localparam logic [1:0] OP_SBC = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b10;
   localparam logic [1:0] OP_RSB = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [1:0]  k;
   logic [1:0]  op_q;
   logic [15:0] first_q;
   logic [15:0] second_q;
   logic        borrow_q;
   logic        zero_q;

   // Bit offset of the current nibble.
   logic [3:0]  nib_lsb;
   logic        diff_zero;

   assign nib_lsb   = {k, 2'b00};
   assign diff_zero = (slice_diff == 4'h0);

   // Both are pure state decodes, so they change only on clock edges.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_comb begin
      slice_a   = 4'h0;
      slice_b   = 4'h0;
      slice_bin = 1'b0;
      if (state == RUN) begin
         slice_a   = first_q[nib_lsb +: 4];
         slice_b   = second_q[nib_lsb +: 4];
         slice_bin = borrow_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         k        <= 2'd0;
         op_q     <= 2'b00;
         first_q  <= 16'h0000;
         second_q <= 16'h0000;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         result   <= 16'h0000;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         flag_b   <= 1'b0;
         flag_v   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  k        <= 2'd0;
                  op_q     <= op;
                  // RSB swaps the operands so the datapath always does first-second.
                  first_q  <= (op == OP_RSB) ? b : a;
                  second_q <= (op == OP_RSB) ? a : b;
                  borrow_q <= (op == OP_SBC) ? bin : 1'b0;
                  zero_q   <= 1'b1;
               end
            end
            RUN: begin
               borrow_q <= slice_bout;
               zero_q   <= zero_q & diff_zero;
               if (op_q != OP_CMP) begin
                  result[nib_lsb +: 4] <= slice_diff;
               end
               k <= k + 2'd1;
               if (k == 2'd3) begin
                  state  <= DONE;
                  // Flags come from the live slice outputs of the top nibble.
                  flag_z <= zero_q & diff_zero;
                  flag_n <= slice_diff[3];
                  flag_b <= slice_bout;
                  flag_v <= (first_q[15] ^ second_q[15]) & (first_q[15] ^ slice_diff[3]);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
